if_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the hazard detection unit and the ID stage. It holds the PC, issues single-outstanding requests to instruction memory, and buffers the returned instruction. It obeys PC_EN_IF, reg_FD_stall and reg_FD_flush from the hazard unit, and takes branch redirects from ID.

---
 rtl/if_fetch_stage_if.sv | 24 ++
 rtl/if_fetch_stage.sv | 149 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory request/response bus between fetch stage and imem
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with single-outstanding imem requests and IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_EN_IF,
  input  logic              reg_FD_stall,
  input  logic              reg_FD_flush,
  input  logic              Branch_ID,
  input  logic [31:0]       branch_target_ID,
  if_fetch_stage_if.master  imem,
  output logic [31:0]       PC_IF,
  output logic [31:0]       PC_ID,
  output logic [31:0]       inst_ID,
  output logic              valid_ID,
  output logic              fetch_busy
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic        valid_id_q, valid_id_d;

  logic        load_ok;
  logic        have_inst;
  logic        load_id;
  logic [31:0] new_inst;

  // An instruction is available only if it was not squashed by kill or a same-cycle redirect.
  always_comb begin
    load_ok   = !reg_FD_stall && !reg_FD_flush && PC_EN_IF;
    have_inst = 1'b0;
    new_inst  = buf_q;
    case (state_q)
      S_WAIT: begin
        have_inst = imem.imem_rvalid && !kill_q && !Branch_ID;
        new_inst  = imem.imem_rdata;
      end
      S_HOLD: begin
        have_inst = !Branch_ID;
      end
      default: begin
        have_inst = 1'b0;
      end
    endcase
    load_id = have_inst && load_ok;
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    buf_d   = buf_q;
    case (state_q)
      S_FETCH: begin
        if (imem.imem_req && imem.imem_gnt) begin
          state_d = S_WAIT;
          kill_d  = Branch_ID;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || Branch_ID || load_ok) begin
            state_d = S_FETCH;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (Branch_ID) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (Branch_ID || load_ok) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
        kill_d  = 1'b0;
      end
    endcase
  end

  // Redirect beats sequential advance; flush beats stall on the ID side.
  always_comb begin
    pc_if_d    = pc_if_q;
    pc_id_d    = pc_id_q;
    inst_id_d  = inst_id_q;
    valid_id_d = valid_id_q;
    if (Branch_ID) begin
      pc_if_d = branch_target_ID;
    end else if (load_id) begin
      pc_if_d = pc_if_q + 32'd4;
    end
    if (reg_FD_flush) begin
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
      pc_id_d    = 32'd0;
    end else if (!reg_FD_stall) begin
      if (load_id) begin
        inst_id_d  = new_inst;
        pc_id_d    = pc_if_q;
        valid_id_d = 1'b1;
      end else begin
        inst_id_d  = NOP_INST;
        valid_id_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      kill_q     <= 1'b0;
      buf_q      <= 32'd0;
      pc_if_q    <= RESET_PC;
      pc_id_q    <= 32'd0;
      inst_id_q  <= NOP_INST;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      buf_q      <= buf_d;
      pc_if_q    <= pc_if_d;
      pc_id_q    <= pc_id_d;
      inst_id_q  <= inst_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH) && PC_EN_IF && !rst;
  assign imem.imem_addr = pc_if_q;
  assign PC_IF          = pc_if_q;
  assign PC_ID          = pc_id_q;
  assign inst_ID        = inst_id_q;
  assign valid_ID       = valid_id_q;
  assign fetch_busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage with a randomized imem responder
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pc_en, stall, flush, branch;
  logic [31:0] target;
  logic [31:0] pc_if, pc_id, inst_id;
  logic        valid_id, busy;

  if_fetch_stage_if imem ();

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk              (clk),
    .rst              (rst),
    .PC_EN_IF         (pc_en),
    .reg_FD_stall     (stall),
    .reg_FD_flush     (flush),
    .Branch_ID        (branch),
    .branch_target_ID (target),
    .imem             (imem),
    .PC_IF            (pc_if),
    .PC_ID            (pc_id),
    .inst_ID          (inst_id),
    .valid_ID         (valid_id),
    .fetch_busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_loads = 0;

  // imem responder state
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after an active edge; samples the handshake late in the cycle, then drives imem inputs.
  task automatic step();
    #7;
    if (imem.imem_rvalid) pend = 1'b0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (imem.imem_req && imem.imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem.imem_addr;
      pend_cnt  = int'($urandom_range(lat_max, lat_min));
    end
    @(posedge clk);
    #1;
    imem.imem_rvalid = pend && (pend_cnt == 0);
    imem.imem_rdata  = imem.imem_rvalid ? word_at(pend_addr) : $urandom;
    imem.imem_gnt    = !pend && (int'($urandom_range(99, 0)) < gnt_pct);
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (valid_id !== 1'b1 && n < 20);
    chk({name, "_arrived"}, 32'(valid_id), 32'd1);
  endtask

  // Scoreboard: exp_q holds the PC the next real instruction in ID must carry.
  logic [31:0] exp_q[$];
  logic        p_rst = 1'b1, p_stall = 1'b0, p_flush = 1'b0, p_branch = 1'b0;
  logic        p_req = 1'b0, p_gnt = 1'b0;
  logic [31:0] p_target = 32'd0, p_addr = 32'd0;
  logic [31:0] h_pc = 32'd0, h_inst = 32'd0;
  logic        h_valid = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e;
    chk("imem_addr_eq_pc", imem.imem_addr, pc_if);
    if (rst) chk("req_low_in_reset", 32'(imem.imem_req), 32'd0);
    if (p_rst) begin
      chk("rst_pc_if", pc_if, RESET_PC);
      chk("rst_pc_id", pc_id, 32'd0);
      chk("rst_inst", inst_id, NOP_INST);
      chk("rst_valid", 32'(valid_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      exp_q = {RESET_PC};
    end else if (p_flush) begin
      chk("flush_inst", inst_id, NOP_INST);
      chk("flush_valid", 32'(valid_id), 32'd0);
      chk("flush_pc_id", pc_id, 32'd0);
    end else if (p_stall) begin
      chk("stall_pc_id", pc_id, h_pc);
      chk("stall_inst", inst_id, h_inst);
      chk("stall_valid", 32'(valid_id), 32'(h_valid));
    end else if (p_branch) begin
      chk("branch_no_load", 32'(valid_id), 32'd0);
    end else if (valid_id) begin
      e = exp_q.pop_front();
      chk("id_pc", pc_id, e);
      chk("id_inst", inst_id, word_at(e));
      exp_q.push_back(e + 32'd4);
      n_loads++;
    end else begin
      chk("bubble_inst", inst_id, NOP_INST);
    end
    if (!p_rst && p_branch) begin
      exp_q.delete();
      exp_q.push_back(p_target);
    end
    if (p_req && !p_gnt && !p_rst && !p_branch && pc_en && !rst) begin
      chk("req_stable", 32'(imem.imem_req), 32'd1);
      chk("addr_stable", imem.imem_addr, p_addr);
    end
    p_rst    = rst;
    p_stall  = stall;
    p_flush  = flush;
    p_branch = branch;
    p_target = target;
    p_req    = imem.imem_req;
    p_gnt    = imem.imem_gnt;
    p_addr   = imem.imem_addr;
    h_pc     = pc_id;
    h_inst   = inst_id;
    h_valid  = valid_id;
  end

  initial begin
    logic [31:0] hold_pc;
    rst = 1'b1; pc_en = 1'b1; stall = 1'b0; flush = 1'b0; branch = 1'b0; target = 32'd0;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'd0;
    pend = 1'b0; pend_addr = 32'd0; pend_cnt = 0;
    @(posedge clk);
    #1;
    step();
    chk("req_during_reset", 32'(imem.imem_req), 32'd0);
    rst = 1'b0;

    // straight-line fetch, 1-cycle latency: 4 instructions in 8 cycles
    repeat (8) step();
    chk("seq_pc_id", pc_id, 32'd12);
    chk("seq_inst", inst_id, 32'd3);
    chk("seq_valid", 32'(valid_id), 32'd1);
    chk("seq_pc_if", pc_if, 32'd16);

    // stall while the response returns -> buffered, then loaded
    stall = 1'b1;
    repeat (3) step();
    chk("stall_hold_pc_id", pc_id, 32'd12);
    chk("stall_hold_inst", inst_id, 32'd3);
    chk("stall_hold_pc_if", pc_if, 32'd16);
    chk("stall_in_hold_busy", 32'(busy), 32'd0);
    chk("stall_in_hold_req", 32'(imem.imem_req), 32'd0);
    stall = 1'b0;
    step();
    chk("unstall_pc_id", pc_id, 32'd16);
    chk("unstall_inst", inst_id, 32'd4);
    chk("unstall_pc_if", pc_if, 32'd20);

    // redirect while waiting: late response dropped
    lat_min = 2; lat_max = 2;
    step();
    chk("wait_busy", 32'(busy), 32'd1);
    branch = 1'b1; target = 32'h100;
    step();
    branch = 1'b0;
    chk("redirect_pc_if", pc_if, 32'h100);
    chk("redirect_busy", 32'(busy), 32'd1);
    step();
    step();
    chk("killed_valid", 32'(valid_id), 32'd0);
    chk("refetch_req", 32'(imem.imem_req), 32'd1);
    chk("refetch_addr", imem.imem_addr, 32'h100);
    lat_min = 0; lat_max = 0;
    wait_load("redirect");
    chk("redirect_pc_id", pc_id, 32'h100);
    chk("redirect_inst", inst_id, 32'h40);

    // flush overrides stall
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_stall_inst", inst_id, NOP_INST);
    chk("flush_stall_valid", 32'(valid_id), 32'd0);
    stall = 1'b0; flush = 1'b0;
    wait_load("after_flush");

    // PC_EN_IF low in FETCH, then grant withheld 4 cycles
    pc_en = 1'b0; gnt_pct = 0;
    hold_pc = pc_if;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pcen_req_low", 32'(imem.imem_req), 32'd0);
      chk("pcen_pc_held", pc_if, hold_pc);
    end
    pc_en = 1'b1;
    #1;
    chk("pcen_resume_req", 32'(imem.imem_req), 32'd1);
    chk("pcen_resume_addr", imem.imem_addr, hold_pc);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nogrant_req", 32'(imem.imem_req), 32'd1);
      chk("nogrant_addr", imem.imem_addr, hold_pc);
    end
    gnt_pct = 100;
    wait_load("after_nogrant");
    chk("after_nogrant_pc_id", pc_id, hold_pc);

    // PC wrap at the top of the address space
    branch = 1'b1; target = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    wait_load("wrap");
    chk("wrap_pc_id", pc_id, 32'hFFFF_FFFC);
    chk("wrap_inst", inst_id, 32'h3FFF_FFFF);
    chk("wrap_pc_if", pc_if, 32'h0000_0000);
    wait_load("post_wrap");
    chk("post_wrap_pc_id", pc_id, 32'h0);

    // reset while a response is still in flight
    lat_min = 1; lat_max = 1;
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_pc_if", pc_if, RESET_PC);
    chk("mid_rst_valid", 32'(valid_id), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step();
    chk("late_rvalid_ignored_valid", 32'(valid_id), 32'd0);
    chk("late_rvalid_ignored_busy", 32'(busy), 32'd0);
    lat_min = 0; lat_max = 0;
    wait_load("after_rst");
    chk("after_rst_pc_id", pc_id, RESET_PC);
    chk("after_rst_inst", inst_id, 32'd0);

    // randomized traffic
    gnt_pct = 70; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(199, 0) == 0);
      stall  = ($urandom_range(7, 0) == 0);
      flush  = ($urandom_range(15, 0) == 0);
      pc_en  = ($urandom_range(9, 0) != 0);
      branch = ($urandom_range(19, 0) == 0);
      target = $urandom & 32'hFFFF_FFFC;
      step();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; pc_en = 1'b1; branch = 1'b0;
    step();
    #5;
    chk("random_load_count_min", 32'(n_loads >= 150), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
